// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and defaults for the memory-stage access controller.
// States, bus width and timeout limit used across the slice.
package mem_stage_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_MAX_WAIT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Handshaked data-memory bus between the MEM stage and backing memory.
// master = access controller, slave = memory.
interface mem_stage_ctrl_if #(
  parameter int DATA_W = 16
) ();

  logic              mem_req;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_dump;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_wr, mem_addr,
    output mem_wdata, mem_dump,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_wr, mem_addr,
    input  mem_wdata, mem_dump,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/mem_stage_ctrl_wait_counter.sv
// Wait-cycle counter with sync clear, enable and terminal count.
// tc flags the cycle in which the count equals MAX_WAIT.
module mem_wait_counter #(
  parameter int CNT_W    = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + CNT_W'(1);
  end

  assign tc = (cnt == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: turns an EX/MEM request into a req/ack
// memory transaction and drives stall, done and sticky error.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_en,
  input  logic              req_wr,
  input  logic              req_dump,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  mem_stage_ctrl_if.master  mem,
  output logic [DATA_W-1:0] rdata_out,
  output logic              stall_out,
  output logic              done_out,
  output logic              err
);

  state_t            state, nxt;
  logic              start, misal, tc;
  logic              in_idle, in_wait;
  logic              wr_q, dump_q;
  logic [DATA_W-1:0] addr_q, wdata_q;

  assign misal   = req_addr[0];
  assign in_idle = (state == IDLE);
  assign in_wait = (state == WAIT);

  always_comb begin
    nxt   = state;
    start = 1'b0;
    unique case (state)
      IDLE: if (req_en && !misal) begin
        nxt   = WAIT;
        start = 1'b1;
      end
      WAIT: if (mem.mem_ack || tc) nxt = DONE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  // count includes the current WAIT cycle, so tc hits on the MAX_WAIT-th
  mem_wait_counter #(
    .CNT_W   (CNT_W),
    .MAX_WAIT(MAX_WAIT)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(~start & ~in_wait),
    .en (start | in_wait),
    .tc (tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      dump_q    <= 1'b0;
      rdata_out <= '0;
      err       <= 1'b0;
    end else begin
      dump_q <= in_idle & req_dump;
      if (start) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wr_q    <= req_wr;
      end
      if (in_idle && req_en && misal) err <= 1'b1;
      if (in_wait) begin
        if (mem.mem_ack) begin
          if (!wr_q) rdata_out <= mem.mem_rdata;
        end else if (tc) begin
          err       <= 1'b1;
          rdata_out <= '0;
        end
      end
    end
  end

  assign mem.mem_req   = in_wait;
  assign mem.mem_wr    = in_wait & wr_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_dump  = dump_q;

  assign stall_out = req_en & ~misal & (state != DONE);
  assign done_out  = (state == DONE);

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed and random accesses checked
// against transaction-level latency and data rules.
module tb_mem_stage_ctrl;
  import mem_stage_pkg::*;

  localparam int DW = 16;
  localparam int TO_LAT = DEF_MAX_WAIT + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          req_en = 1'b0;
  logic          req_wr = 1'b0;
  logic          req_dump = 1'b0;
  logic [DW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [DW-1:0] rdata_out;
  logic          stall_out, done_out, err;

  mem_stage_ctrl_if #(.DATA_W(DW)) mif ();

  mem_stage_ctrl #(
    .DATA_W  (DW),
    .MAX_WAIT(DEF_MAX_WAIT),
    .CNT_W   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_en   (req_en),
    .req_wr   (req_wr),
    .req_dump (req_dump),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .mem      (mif),
    .rdata_out(rdata_out),
    .stall_out(stall_out),
    .done_out (done_out),
    .err      (err)
  );

  int total = 0;
  int bad = 0;
  logic [DW-1:0] m_rdata = '0;
  logic          m_err = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // k >= 0: ack arrives k cycles after mem_req rises; k < 0: never
  task automatic access(input logic wr, input logic [DW-1:0] addr,
                        input logic [DW-1:0] wdata,
                        input logic [DW-1:0] rdata, input int k);
    int lat;
    lat = (k >= 0) ? k + 2 : TO_LAT;
    for (int c = 0; c <= lat; c++) begin
      step();
      req_en    = 1'b1;
      req_wr    = wr;
      req_dump  = 1'b0;
      req_addr  = addr;
      req_wdata = wdata;
      mif.mem_ack   = (k >= 0 && c == k + 1);
      mif.mem_rdata = mif.mem_ack ? rdata : DW'($urandom);
      #3;
      chk("stall", stall_out, c < lat);
      chk("done", done_out, c == lat);
      chk("mem_req", mif.mem_req, c >= 1 && c < lat);
      if (c >= 1 && c < lat) begin
        chk("mem_wr", mif.mem_wr, wr);
        chk("mem_addr", mif.mem_addr, addr);
        chk("mem_wdata", mif.mem_wdata, wdata);
      end
      if (c == lat) begin
        if (k < 0) begin
          m_rdata = '0;
          m_err   = 1'b1;
        end else if (!wr) begin
          m_rdata = rdata;
        end
        chk("rdata", rdata_out, m_rdata);
        chk("err", err, m_err);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      req_en      = 1'b0;
      req_dump    = 1'b0;
      mif.mem_ack = 1'b0;
      #3;
      chk("idle_stall", stall_out, 1'b0);
      chk("idle_done", done_out, 1'b0);
      chk("idle_req", mif.mem_req, 1'b0);
      chk("idle_err", err, m_err);
      chk("idle_rdata", rdata_out, m_rdata);
    end
  endtask

  task automatic misaligned(input logic [DW-1:0] addr);
    for (int c = 0; c < 3; c++) begin
      step();
      req_en   = 1'b1;
      req_wr   = 1'b0;
      req_addr = addr;
      #3;
      chk("mis_stall", stall_out, 1'b0);
      chk("mis_req", mif.mem_req, 1'b0);
      chk("mis_done", done_out, 1'b0);
      chk("mis_err", err, m_err);
      m_err = 1'b1;
    end
  endtask

  initial begin
    int gap, k;
    logic wr;
    logic [DW-1:0] a, wd, rd;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = '0;
    #3;
    chk("rst_req", mif.mem_req, 1'b0);
    chk("rst_done", done_out, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rdata", rdata_out, '0);
    chk("rst_addr", mif.mem_addr, '0);
    chk("rst_dump", mif.mem_dump, 1'b0);
    #9 rst = 1'b1;

    idle(1);
    access(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 3);
    idle(1);
    access(1'b1, 16'h0020, 16'h1234, 16'h5555, 1);
    idle(1);
    access(1'b0, 16'h0002, 16'h0000, 16'h1111, 1);
    access(1'b0, 16'h0004, 16'h0000, 16'h2222, 1);
    idle(1);

    step();
    req_dump = 1'b1;
    #3 chk("dump0", mif.mem_dump, 1'b0);
    step();
    req_dump = 1'b0;
    #3 chk("dump1", mif.mem_dump, 1'b1);
    step();
    #3 chk("dump2", mif.mem_dump, 1'b0);

    for (int n = 0; n < 40; n++) begin
      gap = $urandom_range(0, 2);
      if (gap > 0) idle(gap);
      wr = 1'($urandom_range(0, 1));
      a  = DW'($urandom) & 16'hFFFE;
      wd = DW'($urandom);
      rd = DW'($urandom);
      k  = $urandom_range(0, 6);
      access(wr, a, wd, rd, k);
    end
    access(1'b0, 16'h0040, 16'h0000, 16'hA5A5, 13);
    idle(1);

    misaligned(16'h0003);
    idle(2);
    access(1'b0, 16'h0008, 16'h0000, 16'h7777, -1);
    idle(1);

    step();
    req_en = 1'b1; req_wr = 1'b0; req_addr = 16'h0008;
    step();
    step();
    #2;
    rst = 1'b0;
    req_en = 1'b0;
    #1;
    m_err = 1'b0;
    m_rdata = '0;
    chk("mid_req", mif.mem_req, 1'b0);
    chk("mid_err", err, 1'b0);
    chk("mid_rdata", rdata_out, '0);
    chk("mid_addr", mif.mem_addr, '0);
    chk("mid_done", done_out, 1'b0);
    chk("mid_stall", stall_out, 1'b0);
    step();
    rst = 1'b1;
    step();
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 16'hDEAD;
    #3 chk("stale_done", done_out, 1'b0);
    chk("stale_req", mif.mem_req, 1'b0);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
